multi_trigout_gen: RTL and testbench
====================================

// Module: multi_trigout_gen
// PURPOSE
//  N_CH-channel trigger output generator for the AFG trigger-out path.
//  Per channel: synchronise async trigger input, detect selected edge(s), divide edge count,
//  then drive output as toggle, fixed-width pulse, divided pulse, or follow.
//  Sits between external/internal trigger sources and the rear/front trigger output pins.
// PARAMETERS
//  N_CH        4   number of independent trigger channels
//  CNT_W       16  width of edge-divide and pulse-width counters
//  SYNC_STAGES 2   input synchroniser depth (>=1)
// PORTS
//  Clock     in   1          system clock, all logic on rising edge
//  Reset     in   1          synchronous, active-high; priority over everything
//  EN        in   1          global enable; 0 = clear all channel state, outputs 0
//  Trig_in   in   N_CH       async trigger inputs, bit i = channel i
//  Edge_sel  in   2*N_CH     per ch [2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both
//  Mode      in   2*N_CH     per ch [2i+1:2i]: 00 TOGGLE, 01 PULSE, 10 DIV_PULSE, 11 FOLLOW
//  Div_n     in   CNT_W      edges per event, shared by all ch; 0 treated as 1
//  Pulse_w   in   CNT_W      pulse width in Clock cycles, shared; 0 treated as 1
//  Trig_out  out  N_CH       registered trigger outputs
//  Evt       out  N_CH       registered 1-cycle strobe per fired event, same cycle as Trig_out update
// BEHAVIOUR
//  Reset=1 or EN=0: sync chain, history flop, det, edge cnt, pulse cnt, Trig_out, Evt all 0 next edge.
//  Pipeline per ch: sync[0..S-1] -> prev (= old sync[S-1]) -> det (registered) -> counters/outputs.
//  det = (rise & sync[S-1] & ~prev) | (fall & ~sync[S-1] & prev); Edge_sel 00 -> det never set.
//  Latency: first edge sampling new Trig_in level = edge 1; det=1 after edge S+1;
//   Trig_out/Evt update at edge S+2 (4 cycles for S=2). Fixed for every mode.
//  Edge counter ecnt (CNT_W): on det, if ecnt >= Div_n_eff-1 -> ecnt=0, fire; else ecnt+1.
//   Div_n lowered below ecnt: next det fires and wraps to 0 (no overrun).
//   Div_n_eff=1: every qualified edge fires.
//  TOGGLE: fire -> Trig_out inverts; Evt=1.
//  PULSE: every det fires (ecnt held 0, Div_n ignored); pcnt loaded with Pulse_w_eff;
//   Trig_out = (pcnt!=0) registered; width exactly Pulse_w_eff cycles.
//  DIV_PULSE: as PULSE but loads only on divided fire.
//  Retrigger while pcnt!=0: reload wins over decrement, pulse extends; no gap, Evt=1.
//  FOLLOW: Trig_out = sync[S-1] delayed to same S+2 latency; Edge_sel/Div_n/Pulse_w ignored;
//   Evt = det.
//  Mode change on a channel (registered Mode differs from input): that ch's ecnt, pcnt,
//   Trig_out cleared next edge; new mode active from the following edge.
//  Edge_sel change: takes effect on next det evaluation; counters not cleared.
//  Div_n/Pulse_w changes: sampled at fire/load time only; running pulse keeps its length.
//  pcnt never underflows: decrement only when nonzero.
//  Channels fully independent; simultaneous events on all ch handled in same cycle.
//  EN rising: first possible det requires a level change after re-enable (prev starts 0,
//   so an input already high reads as a rise after S+1 edges).
// TESTING
//  T1 Reset: Reset=1 3 cycles, Trig_in toggling -> Trig_out=0, Evt=0 throughout and 1 cycle after.
//  T2 TOGGLE ch0, Edge_sel=10, Div_n=1: 3 falling edges on Trig_in[0] -> Trig_out[0] 0->1->0->1,
//   each 4 cycles after the falling-edge sample.
//  T3 DIV_PULSE ch1, Edge_sel=01, Div_n=3, Pulse_w=5: 6 rising edges ->
//   exactly 2 pulses, each 5 cycles high, on the 3rd and 6th edge.
//  T4 PULSE ch2, Edge_sel=11, Pulse_w=4: second edge arrives 2 cycles into pulse ->
//   Trig_out high continuously 6 cycles, Evt pulses twice.
//  T5 Boundaries: Div_n=0 and Pulse_w=0 -> behave as 1.
//   Div_n 8->2 with ecnt=5 -> next edge fires, ecnt=0.
//  T6 EN dropped mid-pulse (ch1 pcnt=3) -> Trig_out=0 next edge; EN=1 with no input change ->
//   no Evt on a low input.

Source files
------------

// File: rtl/multi_trigout_gen_if.sv
// Bus for the multi-channel trigger-out generator: trigger/control inputs
// toward the generator and its registered trigger/event outputs.
interface multi_trigout_gen_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
);
  logic              EN;
  logic [N_CH-1:0]   Trig_in;
  logic [2*N_CH-1:0] Edge_sel;
  logic [2*N_CH-1:0] Mode;
  logic [CNT_W-1:0]  Div_n;
  logic [CNT_W-1:0]  Pulse_w;
  logic [N_CH-1:0]   Trig_out;
  logic [N_CH-1:0]   Evt;

  modport master (
    output EN, Trig_in, Edge_sel, Mode, Div_n, Pulse_w,
    input  Trig_out, Evt
  );

  modport slave (
    input  EN, Trig_in, Edge_sel, Mode, Div_n, Pulse_w,
    output Trig_out, Evt
  );
endinterface

// File: rtl/multi_trigout_gen.sv
// N-channel trigger-out generator: synchronise, qualify edges, divide, then
// drive each output as toggle, fixed pulse, divided pulse or delayed follow.
module multi_trigout_gen #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic                Clock,
  input logic                Reset,
  multi_trigout_gen_if.slave bus
);
  localparam logic [1:0] MODE_TOGGLE    = 2'b00;
  localparam logic [1:0] MODE_PULSE     = 2'b01;
  localparam logic [1:0] MODE_DIV_PULSE = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] div_eff_s;
  logic [CNT_W-1:0] pw_eff_s;
  logic [N_CH-1:0]  trig_out_s;
  logic [N_CH-1:0]  evt_s;

  // A zero divide ratio or pulse width is treated as one.
  always_comb begin
    div_eff_s = bus.Div_n;
    pw_eff_s  = bus.Pulse_w;
    if (bus.Div_n == CNT_ZERO) div_eff_s = CNT_ONE;
    else                       div_eff_s = bus.Div_n;
    if (bus.Pulse_w == CNT_ZERO) pw_eff_s = CNT_ONE;
    else                         pw_eff_s = bus.Pulse_w;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   det_r;
    logic [1:0]             mode_r;
    logic [CNT_W-1:0]       ecnt_r;
    logic [CNT_W-1:0]       pcnt_r;
    logic                   out_r;
    logic                   evt_r;

    logic [1:0]       esel_s;
    logic [1:0]       mode_s;
    logic             lvl_s;
    logic             det_s;
    logic             fire_s;
    logic [CNT_W-1:0] ecnt_s;
    logic [CNT_W-1:0] pcnt_s;
    logic             out_s;
    logic             evt_nx_s;

    assign esel_s = bus.Edge_sel[2*i +: 2];
    assign mode_s = bus.Mode[2*i +: 2];
    assign lvl_s  = sync_r[SYNC_STAGES-1];

    // Edge qualification, edge divide and per-mode output selection.
    always_comb begin
      det_s    = (esel_s[0] & lvl_s & ~prev_r) | (esel_s[1] & ~lvl_s & prev_r);
      fire_s   = 1'b0;
      ecnt_s   = ecnt_r;
      pcnt_s   = pcnt_r;
      out_s    = out_r;
      evt_nx_s = 1'b0;
      case (mode_r)
        MODE_TOGGLE, MODE_DIV_PULSE: begin
          if (det_r) begin
            // >= rather than == so a lowered Div_n wraps instead of overrunning.
            if (ecnt_r >= div_eff_s - CNT_ONE) begin
              ecnt_s = CNT_ZERO;
              fire_s = 1'b1;
            end else begin
              ecnt_s = ecnt_r + CNT_ONE;
              fire_s = 1'b0;
            end
          end else begin
            ecnt_s = ecnt_r;
            fire_s = 1'b0;
          end
        end
        MODE_PULSE: begin
          ecnt_s = CNT_ZERO;
          fire_s = det_r;
        end
        default: begin
          ecnt_s = CNT_ZERO;
          fire_s = 1'b0;
        end
      endcase
      case (mode_r)
        MODE_TOGGLE: begin
          pcnt_s   = CNT_ZERO;
          out_s    = out_r ^ fire_s;
          evt_nx_s = fire_s;
        end
        MODE_PULSE, MODE_DIV_PULSE: begin
          if (fire_s)                  pcnt_s = pw_eff_s;
          else if (pcnt_r != CNT_ZERO) pcnt_s = pcnt_r - CNT_ONE;
          else                         pcnt_s = pcnt_r;
          out_s    = (pcnt_s != CNT_ZERO);
          evt_nx_s = fire_s;
        end
        default: begin
          pcnt_s   = CNT_ZERO;
          out_s    = prev_r;
          evt_nx_s = det_r;
        end
      endcase
    end

    // Channel state: reset/disable clear all, a mode change clears the output side.
    always_ff @(posedge Clock) begin
      if (Reset || !bus.EN) begin
        sync_r <= {SYNC_STAGES{1'b0}};
        prev_r <= 1'b0;
        det_r  <= 1'b0;
        mode_r <= mode_s;
        ecnt_r <= CNT_ZERO;
        pcnt_r <= CNT_ZERO;
        out_r  <= 1'b0;
        evt_r  <= 1'b0;
      end else begin
        for (int k = SYNC_STAGES - 1; k > 0; k--) sync_r[k] <= sync_r[k-1];
        sync_r[0] <= bus.Trig_in[i];
        prev_r    <= lvl_s;
        det_r     <= det_s;
        mode_r    <= mode_s;
        if (mode_s != mode_r) begin
          ecnt_r <= CNT_ZERO;
          pcnt_r <= CNT_ZERO;
          out_r  <= 1'b0;
          evt_r  <= 1'b0;
        end else begin
          ecnt_r <= ecnt_s;
          pcnt_r <= pcnt_s;
          out_r  <= out_s;
          evt_r  <= evt_nx_s;
        end
      end
    end

    assign trig_out_s[i] = out_r;
    assign evt_s[i]      = evt_r;
  end

  assign bus.Trig_out = trig_out_s;
  assign bus.Evt      = evt_s;
endmodule

// File: tb/tb_multi_trigout_gen.sv
// Scoreboard bench for multi_trigout_gen: a sample-history reference model
// predicts every cycle's outputs; directed scenarios add event/width totals.
module tb_multi_trigout_gen;
  localparam int N_CH  = 4;
  localparam int CNT_W = 16;
  localparam int S     = 2;
  localparam int MAXC  = 16384;

  typedef struct packed {
    logic [N_CH-1:0] out;
    logic [N_CH-1:0] evt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   evt_cnt [N_CH];
  int   hi_cnt  [N_CH];

  multi_trigout_gen_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  multi_trigout_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .SYNC_STAGES(S)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: input samples per edge, cleared below clr[c].
  bit         samp   [N_CH][MAXC];
  logic [1:0] esel_h [N_CH][MAXC];
  int         clr    [N_CH];
  logic [1:0] mode_m [N_CH];
  int         ecnt_m [N_CH];
  int         pend_m [N_CH];
  bit         out_m  [N_CH];
  exp_t       exp_q  [$];

  function automatic bit lvl(int c, int m);
    if (m < 0 || m <= clr[c]) return 1'b0;
    return samp[c][m];
  endfunction

  // Model: the output stage sees the input level sampled S+1 edges earlier.
  initial begin
    int cyc, dv, pw;
    bit a, b, ev, fire;
    logic [1:0] md, es;
    exp_t e;
    cyc = 0;
    for (int c = 0; c < N_CH; c++) begin
      clr[c] = -1; mode_m[c] = 2'b00; ecnt_m[c] = 0; pend_m[c] = 0; out_m[c] = 1'b0;
    end
    forever begin
      @(posedge clk);
      e  = '0;
      dv = (bus.Div_n == '0) ? 1 : int'(bus.Div_n);
      pw = (bus.Pulse_w == '0) ? 1 : int'(bus.Pulse_w);
      for (int c = 0; c < N_CH; c++) begin
        md = bus.Mode[2*c +: 2];
        samp[c][cyc]   = bus.Trig_in[c];
        esel_h[c][cyc] = bus.Edge_sel[2*c +: 2];
        if (rst || !bus.EN) begin
          clr[c] = cyc; mode_m[c] = md; ecnt_m[c] = 0; pend_m[c] = 0; out_m[c] = 1'b0;
        end else begin
          a  = lvl(c, cyc - S - 2);
          b  = lvl(c, cyc - S - 1);
          es = (cyc >= 1) ? esel_h[c][cyc-1] : 2'b00;
          ev = (es[0] && !a && b) || (es[1] && a && !b);
          if (md != mode_m[c]) begin
            mode_m[c] = md; ecnt_m[c] = 0; pend_m[c] = 0; out_m[c] = 1'b0;
          end else begin
            fire = 1'b0;
            if (mode_m[c] == 2'b01) fire = ev;
            else if (mode_m[c] != 2'b11 && ev) begin
              if (ecnt_m[c] >= dv - 1) begin ecnt_m[c] = 0; fire = 1'b1; end
              else ecnt_m[c]++;
            end
            case (mode_m[c])
              2'b00: begin
                if (fire) out_m[c] = !out_m[c];
                e.evt[c] = fire;
              end
              2'b01, 2'b10: begin
                if (fire) pend_m[c] = cyc + pw;
                out_m[c] = (cyc < pend_m[c]);
                e.evt[c] = fire;
              end
              default: begin
                out_m[c] = b;
                e.evt[c] = ev;
              end
            endcase
          end
        end
        e.out[c] = out_m[c];
      end
      exp_q.push_back(e);
      if (cyc < MAXC - 1) cyc++;
    end
  end

  // Monitor: compare every presented output cycle against the scoreboard.
  initial begin
    exp_t e;
    int mcyc;
    mcyc = 0;
    for (int c = 0; c < N_CH; c++) begin evt_cnt[c] = 0; hi_cnt[c] = 0; end
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.Trig_out !== e.out) begin
          errors++;
          $display("FAIL trig_out cycle %0d: got %b expected %b", mcyc, bus.Trig_out, e.out);
        end
        checks++;
        if (bus.Evt !== e.evt) begin
          errors++;
          $display("FAIL evt cycle %0d: got %b expected %b", mcyc, bus.Evt, e.evt);
        end
        for (int c = 0; c < N_CH; c++) begin
          if (bus.Evt[c] === 1'b1)      evt_cnt[c]++;
          if (bus.Trig_out[c] === 1'b1) hi_cnt[c]++;
        end
        mcyc++;
      end
    end
  end

  task automatic wait_cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ch(int c, logic [1:0] md, logic [1:0] es);
    bus.Mode[2*c +: 2]     = md;
    bus.Edge_sel[2*c +: 2] = es;
  endtask

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic pulses(int c, int n, int gap);
    for (int k = 0; k < n; k++) begin
      bus.Trig_in[c] = 1'b1; wait_cyc(gap);
      bus.Trig_in[c] = 1'b0; wait_cyc(gap);
    end
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    int e0, h0;
    rst = 1'b1; bus.EN = 1'b1; bus.Trig_in = '0; bus.Edge_sel = '0; bus.Mode = '0;
    bus.Div_n = 16'd1; bus.Pulse_w = 16'd1;
    for (int k = 0; k < 3; k++) begin bus.Trig_in = ~bus.Trig_in; wait_cyc(1); end
    rst = 1'b0; bus.Trig_in = '0;
    wait_cyc(8);

    // Toggle on falling edges, divide by one.
    set_ch(0, 2'b00, 2'b10);
    wait_cyc(3);
    e0 = evt_cnt[0];
    pulses(0, 3, 6);
    wait_cyc(8);
    chk("t2_evt_count", evt_cnt[0] - e0, 3);
    chk("t2_final_level", int'(bus.Trig_out[0]), 1);

    // Divided pulse: 6 rises, divide 3, width 5.
    set_ch(1, 2'b10, 2'b01); bus.Div_n = 16'd3; bus.Pulse_w = 16'd5;
    wait_cyc(3);
    e0 = evt_cnt[1]; h0 = hi_cnt[1];
    pulses(1, 6, 8);
    wait_cyc(10);
    chk("t3_evt_count", evt_cnt[1] - e0, 2);
    chk("t3_high_cycles", hi_cnt[1] - h0, 10);

    // Retriggered pulse on both edges, 2 cycles apart.
    set_ch(2, 2'b01, 2'b11); bus.Pulse_w = 16'd4;
    wait_cyc(3);
    e0 = evt_cnt[2]; h0 = hi_cnt[2];
    bus.Trig_in[2] = 1'b1; wait_cyc(2);
    bus.Trig_in[2] = 1'b0; wait_cyc(12);
    chk("t4_evt_count", evt_cnt[2] - e0, 2);
    chk("t4_high_cycles", hi_cnt[2] - h0, 6);

    // Zero divide/width behave as one.
    set_ch(3, 2'b10, 2'b01); bus.Div_n = 16'd0; bus.Pulse_w = 16'd0;
    wait_cyc(3);
    e0 = evt_cnt[3]; h0 = hi_cnt[3];
    pulses(3, 2, 6);
    wait_cyc(8);
    chk("t5_zero_evt", evt_cnt[3] - e0, 2);
    chk("t5_zero_high", hi_cnt[3] - h0, 2);

    // Lower Div_n below the running edge count.
    set_ch(3, 2'b00, 2'b01); bus.Div_n = 16'd8;
    wait_cyc(3);
    e0 = evt_cnt[3];
    pulses(3, 5, 5);
    wait_cyc(6);
    chk("t5_no_fire_yet", evt_cnt[3] - e0, 0);
    bus.Div_n = 16'd2;
    pulses(3, 1, 5);
    wait_cyc(6);
    chk("t5_lowered_fire", evt_cnt[3] - e0, 1);
    chk("t5_toggle_level", int'(bus.Trig_out[3]), 1);

    // Disable mid-pulse, re-enable with a low input.
    bus.Div_n = 16'd1; bus.Pulse_w = 16'd5;
    wait_cyc(2);
    e0 = evt_cnt[1]; h0 = hi_cnt[1];
    bus.Trig_in[1] = 1'b1;
    wait_cyc(6);
    bus.EN = 1'b0; bus.Trig_in[1] = 1'b0;
    wait_cyc(2);
    chk("t6_out_cleared", int'(bus.Trig_out[1]), 0);
    chk("t6_high_cycles", hi_cnt[1] - h0, 3);
    bus.EN = 1'b1;
    e0 = evt_cnt[1];
    wait_cyc(10);
    chk("t6_no_evt_reenable", evt_cnt[1] - e0, 0);

    // Randomized traffic with sporadic config changes, disables and resets.
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, 3) == 0) bus.Trig_in[c] = ~bus.Trig_in[c];
      if ($urandom_range(0, 49) == 0) bus.Edge_sel = (2*N_CH)'($urandom);
      if ($urandom_range(0, 99) == 0) bus.Mode = (2*N_CH)'($urandom);
      if ($urandom_range(0, 39) == 0)
        bus.Div_n = ($urandom_range(0, 9) == 0) ? 16'hFFFF : CNT_W'($urandom_range(0, 4));
      if ($urandom_range(0, 39) == 0) bus.Pulse_w = CNT_W'($urandom_range(0, 6));
      bus.EN = ($urandom_range(0, 199) != 0);
      rst    = ($urandom_range(0, 499) == 0);
    end
    rst = 1'b0; bus.EN = 1'b1;
    wait_cyc(8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
